// File: rtl/adc_trigger_capture.sv
//------------------------------------------------------------------------------
// adc_trigger_capture
//
// Capture stage behind the ADC socket. Every sample lands in a circular RAM.
// After arm, pre_len samples of history are collected. Writing then continues
// (overwriting the oldest history) until an edge/level hit or force_trig.
// post_len further samples are recorded, and the record is frozen for
// oldest-first readout.
//
// Ports:
//   adc_clk     sample clock, single clock domain
//   rstn        synchronous active-low reset
//   adc_data    raw ADC sample, valid every cycle
//   arm         pulse: start a capture (IDLE or DONE only)
//   abort       pulse: back to IDLE from any state, highest priority
//   force_trig  force the trigger while waiting for it
//   trig_edge   0 = rising, 1 = falling
//   trig_level  unsigned trigger threshold
//   pre_len     samples kept before the trigger sample
//   post_len    samples recorded after the trigger sample
//   state       IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4
//   triggered   high from the trigger sample until arm/abort/reset
//   done        high while the record is frozen
//   rd_req      request the next record sample
//   rd_data     read sample, valid with rd_valid
//   rd_valid    one-cycle pulse, one cycle after an accepted rd_req
//   rd_last     marks the final record sample
//------------------------------------------------------------------------------
module adc_trigger_capture #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          adc_clk,
    input  logic          rstn,
    input  logic [DW-1:0] adc_data,
    input  logic          arm,
    input  logic          abort,
    input  logic          force_trig,
    input  logic          trig_edge,
    input  logic [DW-1:0] trig_level,
    input  logic [AW-1:0] pre_len,
    input  logic [AW-1:0] post_len,
    output logic [2:0]    state,
    output logic          triggered,
    output logic          done,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_last
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state, w_next_state;

    logic [DW-1:0] r_mem [0:DEPTH-1];

    logic [DW-1:0] r_s_cur, r_s_prev;
    logic          r_edge;
    logic [DW-1:0] r_level;
    logic [AW-1:0] r_pre, r_post;
    logic [AW:0]   r_len;
    logic [AW-1:0] r_wp, r_cnt, r_rd_ptr;
    logic [AW:0]   r_rd_cnt;
    logic          r_triggered, r_rd_valid, r_rd_last;
    logic [DW-1:0] r_rd_data;

    logic [AW:0]   w_sum, w_len_cfg;
    logic [AW-1:0] w_post_sat, w_cnt_inc;
    logic          w_hit, w_trig, w_we, w_rd_fire, w_arm_ok;

    // Saturate post_len so the whole record fits in the RAM; ~pre_len is
    // exactly 2^AW - 1 - pre_len.
    assign w_sum      = (AW+1)'(pre_len) + (AW+1)'(post_len) + (AW+1)'(1);
    assign w_post_sat = (w_sum > (AW+1)'(DEPTH)) ? ~pre_len : post_len;
    assign w_len_cfg  = (AW+1)'(pre_len) + (AW+1)'(w_post_sat) + (AW+1)'(1);

    assign w_hit = r_edge ? ((r_s_prev > r_level) && (r_s_cur <= r_level))
                          : ((r_s_prev < r_level) && (r_s_cur >= r_level));

    assign w_arm_ok  = arm && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_trig    = (r_state == S_WAIT) && !abort && (w_hit || force_trig);
    assign w_we      = !abort && (r_state == S_PRE || r_state == S_WAIT || r_state == S_POST);
    assign w_rd_fire = (r_state == S_DONE) && rd_req && !abort && (r_rd_cnt < r_len);
    assign w_cnt_inc = r_cnt + AW'(1);

    // Input pipeline runs in every state, reset included.
    always_ff @(posedge adc_clk) begin
        r_s_cur  <= adc_data;
        r_s_prev <= r_s_cur;
    end

    always_ff @(posedge adc_clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps every path assigned, so no latch.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else if (w_arm_ok) begin
            w_next_state = (pre_len == '0) ? S_WAIT : S_PRE;
        end else begin
            case (r_state)
                S_PRE:   if (w_cnt_inc == r_pre)  w_next_state = S_WAIT;
                S_WAIT:  if (w_trig)              w_next_state = (r_post == '0) ? S_DONE : S_POST;
                S_POST:  if (w_cnt_inc == r_post) w_next_state = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rstn) begin
            r_edge      <= 1'b0;
            r_level     <= '0;
            r_pre       <= '0;
            r_post      <= '0;
            r_len       <= '0;
            r_wp        <= '0;
            r_cnt       <= '0;
            r_rd_ptr    <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && (r_rd_cnt == r_len - (AW+1)'(1));
            if (abort) begin
                r_triggered <= 1'b0;
            end else if (w_arm_ok) begin
                r_edge      <= trig_edge;
                r_level     <= trig_level;
                r_pre       <= pre_len;
                r_post      <= w_post_sat;
                r_len       <= w_len_cfg;
                r_wp        <= '0;
                r_cnt       <= '0;
                r_rd_cnt    <= '0;
                r_triggered <= 1'b0;
            end else begin
                if (w_we) r_wp <= r_wp + AW'(1);
                if (r_state == S_PRE || r_state == S_POST) r_cnt <= w_cnt_inc;
                if (w_trig) begin
                    // The trigger sample is written at r_wp this cycle, so the
                    // oldest record sample sits pre_len slots behind it.
                    r_cnt       <= '0;
                    r_triggered <= 1'b1;
                    r_rd_ptr    <= r_wp - r_pre;
                    r_rd_cnt    <= '0;
                end
                if (w_rd_fire) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
                end
            end
        end
    end

    // NOTE: the sample RAM has no reset; clearing it would defeat RAM inference
    // and every location is rewritten before it becomes part of a record.
    always_ff @(posedge adc_clk) begin
        if (w_we) r_mem[r_wp] <= r_s_cur;
    end

    always_ff @(posedge adc_clk) begin
        if (!rstn)          r_rd_data <= '0;
        else if (w_rd_fire) r_rd_data <= r_mem[r_rd_ptr];
    end

    assign state     = r_state;
    assign triggered = r_triggered;
    assign done      = (r_state == S_DONE);
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;

endmodule

// File: tb/tb_adc_trigger_capture.sv
//------------------------------------------------------------------------------
// tb_adc_trigger_capture
//
// Scoreboard bench for adc_trigger_capture. Every sample presented to the DUT
// is logged by clock edge. After a capture completes, the record is derived
// from that log: locate the first eligible trigger sample and slice
// pre/trigger/post samples. The expected record is queued for a monitor that
// pops one entry per rd_valid.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_trigger_capture;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          adc_clk    = 1'b0;
    logic          rstn       = 1'b0;
    logic [DW-1:0] adc_data   = '0;
    logic          arm        = 1'b0;
    logic          abort      = 1'b0;
    logic          force_trig = 1'b0;
    logic          trig_edge  = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] pre_len    = '0;
    logic [AW-1:0] post_len   = '0;
    logic          rd_req     = 1'b0;
    logic [2:0]    state;
    logic          triggered, done, rd_valid, rd_last;
    logic [DW-1:0] rd_data;

    adc_trigger_capture #(.DW(DW), .AW(AW)) dut (
        .adc_clk    (adc_clk),
        .rstn       (rstn),
        .adc_data   (adc_data),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
        .trig_edge  (trig_edge),
        .trig_level (trig_level),
        .pre_len    (pre_len),
        .post_len   (post_len),
        .state      (state),
        .triggered  (triggered),
        .done       (done),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last)
    );

    always #5 adc_clk = ~adc_clk;

    typedef enum int {M_UP, M_DN, M_CONST, M_RAND} mode_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    mode_t         mode = M_CONST;
    logic [DW-1:0] val  = '0;
    exp_t          exp_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int arm_edge  = 0;
    int done_rise = -1;
    int trig_rise = -1;
    int rx_cnt    = 0;

    logic [DW-1:0] d_hist     [0:65535];
    bit            force_hist [0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: on the falling edge, drop pulses and present the next sample.
    task automatic step();
        @(negedge adc_clk);
        arm        = 1'b0;
        abort      = 1'b0;
        force_trig = 1'b0;
        rd_req     = 1'b0;
        case (mode)
            M_UP:    val = val + 8'd1;
            M_DN:    val = val - 8'd1;
            M_RAND:  val = 8'($urandom);
            default: ;
        endcase
        adc_data = val;
    endtask

    // Log of what the DUT saw at each rising edge.
    initial forever begin
        @(posedge adc_clk);
        cyc = cyc + 1;
        d_hist[cyc]     = adc_data;
        force_hist[cyc] = force_trig;
        if (arm && !abort && rstn) arm_edge = cyc;
    end

    // Monitor: edge timestamps and scoreboard comparison of the readout.
    initial begin
        logic done_q, trig_q;
        exp_t e;
        done_q = 1'b0;
        trig_q = 1'b0;
        forever begin
            @(negedge adc_clk);
            if (done && !done_q) done_rise = cyc;
            if (triggered && !trig_q) trig_rise = cyc;
            done_q = done;
            trig_q = triggered;
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_data[%0d]", rx_cnt), 32'(rd_data), 32'(e.data));
                    check($sformatf("rd_last[%0d]", rx_cnt), 32'(rd_last), 32'(e.last));
                end
                rx_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1, "watchdog");
    end

    function automatic bit is_hit(logic [DW-1:0] p, logic [DW-1:0] c, logic e, logic [DW-1:0] l);
        return e ? (p > l && c <= l) : (p < l && c >= l);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_state"},     32'(state),     32'd0);
        check({tag, "_triggered"}, 32'(triggered), 32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_last"},   32'(rd_last),   32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
    endtask

    // Arm with the given configuration, scramble the inputs afterwards, wait
    // for done, then queue the record predicted from the sample log.
    task automatic run_capture(input int pre, input int post, input logic e, input logic [DW-1:0] lvl,
                               input int force_after, input int budget, output int len);
        int  post_eff, j, k;
        bit  found;
        trig_edge  = e;
        trig_level = lvl;
        pre_len    = AW'(pre);
        post_len   = AW'(post);
        arm        = 1'b1;
        step();
        trig_edge  = 1'($urandom);
        trig_level = 8'($urandom);
        pre_len    = AW'($urandom);
        post_len   = AW'($urandom);
        done_rise  = -1;
        trig_rise  = -1;
        k = 0;
        while (!done && k < budget) begin
            step();
            if (k == force_after) force_trig = 1'b1;
            k++;
        end
        #1;
        check("done_within_budget", 32'(done), 32'd1);
        post_eff = (pre + post + 1 > DEPTH) ? DEPTH - 1 - pre : post;
        len      = pre + post_eff + 1;
        found    = 1'b0;
        j        = arm_edge + pre;
        while (!found && j < cyc) begin
            if (is_hit(d_hist[j-1], d_hist[j], e, lvl) || force_hist[j+1]) found = 1'b1;
            else j++;
        end
        check("trigger_found", 32'(found), 32'd1);
        if (found) begin
            check("trig_rise_edge", trig_rise, j + 1);
            check("done_rise_edge", done_rise, j + 1 + post_eff);
            for (int i = 0; i < len; i++) exp_q.push_back('{d_hist[j-pre+i], (i == len - 1)});
        end
    endtask

    task automatic readout(input int n_req, input int exp_rx, input bit gaps);
        int issued;
        issued = 0;
        rx_cnt = 0;
        while (issued < n_req) begin
            step();
            rd_req = gaps ? 1'($urandom) : 1'b1;
            if (rd_req) issued++;
        end
        repeat (3) step();
        check("rx_count", rx_cnt, exp_rx);
    endtask

    initial begin
        int len;

        // Reset state
        repeat (3) step();
        check_reset("reset");
        rstn = 1'b1;

        // 1: rising ramp, arm at 0x10, level 0x80, pre 4, post 3
        mode = M_UP;
        val  = 8'h00;
        step();
        while (adc_data != 8'h10) step();
        run_capture(4, 3, 1'b0, 8'h80, -1, 400, len);
        readout(len + 1, len, 1'b0);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: falling ramp from 0xFF, level 0x40, pre 0, post 0
        mode = M_DN;
        val  = 8'h00;
        step();
        run_capture(0, 0, 1'b1, 8'h40, -1, 600, len);
        readout(len + 1, len, 1'b0);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: constant 0x20, forced trigger
        mode = M_CONST;
        val  = 8'h20;
        repeat (2) step();
        run_capture(2, 2, 1'b0, 8'h80, 50, 200, len);
        readout(len + 1, len, 1'b1);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: post saturation, full-RAM record with wrap
        mode = M_UP;
        step();
        run_capture(1000, 100, 1'b0, 8'h80, -1, 2000, len);
        readout(len + 1, len, 1'b0);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: abort during POST, clean re-capture, arm+abort in IDLE
        mode = M_CONST;
        val  = 8'h55;
        step();
        trig_edge  = 1'b0;
        trig_level = 8'hF0;
        pre_len    = AW'(2);
        post_len   = AW'(50);
        arm        = 1'b1;
        repeat (10) step();
        force_trig = 1'b1;
        repeat (5) step();
        check("t5_state_post", 32'(state), 32'd3);
        abort = 1'b1;
        step();
        check("t5_abort_state", 32'(state), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        check("t5_abort_triggered", 32'(triggered), 32'd0);
        repeat (60) step();
        check("t5_done_stays_low", 32'(done), 32'd0);
        mode = M_RAND;
        step();
        run_capture(3, 4, 1'b0, 8'h80, 30, 200, len);
        readout(len + 1, len, 1'b1);
        check("t5_queue_empty", exp_q.size(), 0);
        step();
        abort = 1'b1;
        step();
        arm   = 1'b1;
        abort = 1'b1;
        repeat (3) step();
        check("t5_arm_abort_idle", 32'(state), 32'd0);

        // Randomized captures
        for (int n = 0; n < 6; n++) begin
            run_capture($urandom_range(0, 8), $urandom_range(0, 8), 1'($urandom),
                        8'($urandom_range(8'h30, 8'hD0)), 40, 300, len);
            readout(len + 1, len, 1'b1);
            check("rand_queue_empty", exp_q.size(), 0);
        end

        // 6: reset during readout
        mode = M_UP;
        step();
        run_capture(5, 5, 1'b0, 8'h80, -1, 400, len);
        readout(3, 3, 1'b0);
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b1;
        rstn   = 1'b0;
        step();
        check_reset("t6");
        rstn = 1'b1;
        exp_q.delete();
        readout(4, 0, 1'b0);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_trigger_capture.md
Name: adc_trigger_capture

Overview:
Capture stage directly downstream of the ADC socket. It samples adc_data on every adc_clk and stores it in an internal circular sample RAM. A configurable pre-trigger history is kept until an edge or level trigger (or a forced trigger) occurs. Then a fixed number of post-trigger samples is recorded and the record is frozen for sequential readout by the SPI command layer.

Parameters:
DW, 8, sample width (matches the ADC bus)
AW, 10, RAM address width; depth = 2^AW samples

Ports:
adc_clk  in  1  sample clock; all logic in this domain
rstn  in  1  reset, synchronous, active-low
adc_data  in  DW  raw ADC sample, valid every adc_clk
arm  in  1  single-cycle pulse; starts a capture
abort  in  1  single-cycle pulse; returns to IDLE from any state
force_trig  in  1  forces the trigger while in WAIT_TRIG
trig_edge  in  1  0 = rising, 1 = falling
trig_level  in  DW  trigger threshold, unsigned
pre_len  in  AW  pre-trigger samples to keep
post_len  in  AW  samples to record after the trigger sample
state  out  3  IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4
triggered  out  1  high from the trigger sample until the next arm, abort or reset
done  out  1  high while in DONE
rd_req  in  1  request the next record sample (DONE only)
rd_data  out  DW  read sample
rd_valid  out  1  one-cycle pulse, 1 cycle after an accepted rd_req
rd_last  out  1  coincides with rd_valid for the final record sample

Behaviour:
- Reset (rstn=0 at a clock edge):
  - state=IDLE; triggered, done, rd_valid, rd_last=0; rd_data=0.
  - Pointers and counters=0. RAM contents are not cleared.
- Input pipeline: s_cur <= adc_data and s_prev <= s_cur every cycle, in every state. RAM writes use s_cur.
- Configuration: trig_edge, trig_level, pre_len and post_len are latched on arm; changes after arm are ignored.
- If pre_len + post_len + 1 > 2^AW, the latched post_len is saturated to 2^AW - 1 - pre_len.
- IDLE: no writes. arm -> PRE, and wp=0, cnt=0, triggered=0.
- PRE:
  - Write s_cur at wp; wp++ (wrapping mod 2^AW); cnt++.
  - When cnt reaches pre_len -> WAIT_TRIG.
  - If pre_len=0, arm goes directly to WAIT_TRIG.
  - Trigger conditions are ignored in PRE.
- WAIT_TRIG:
  - Write s_cur at wp every cycle; wp wraps, overwriting the oldest history.
  - Rising hit: s_prev < trig_level and s_cur >= trig_level. Falling hit: s_prev > trig_level and s_cur <= trig_level.
  - On a hit or force_trig: the sample written that cycle is the trigger sample; trig_addr <= wp; triggered=1; cnt=0.
  - Then -> POST, or -> DONE directly if post_len=0.
- POST: write and wp++ each cycle; cnt++. When cnt reaches post_len -> DONE. Exactly post_len samples follow the trigger sample.
- DONE:
  - No writes; done=1.
  - Read pointer starts at trig_addr - pre_len (mod 2^AW). Record length L = pre_len + 1 + post_len.
  - Each rd_req advances the pointer. rd_data and rd_valid appear exactly 1 cycle later (registered RAM read).
  - rd_req after the L-th sample is ignored (no rd_valid).
  - Back-to-back rd_req gives one sample per cycle.
  - Readout is oldest-first; the trigger sample is at index pre_len.
- arm in DONE re-arms (-> PRE) and discards the unread record. arm in PRE, WAIT_TRIG or POST is ignored.
- abort in any state -> IDLE next cycle, with done=0 and triggered=0. abort has priority over arm, trigger and rd_req in the same cycle.
- An in-flight rd_valid from the preceding cycle's rd_req still completes.
- Reset mid-capture or mid-readout: same as reset, and the record is discarded.

Test Plan:
1. Ramp adc_data +1 per clk; arm when ramp=0x10; rising, level=0x80, pre=4, post=3 -> trigger on sample 0x80. Readout of 8 samples gives 0x7C..0x83, with rd_last on 0x83.
2. Ramp decreasing from 0xFF; falling, level=0x40, pre=0, post=0 -> a single sample 0x40 read. A 2nd rd_req gives no rd_valid.
3. Constant adc_data=0x20, level=0x80, pre=2, post=2; force_trig after 50 clks -> 5 samples, all 0x20. triggered rises on the force cycle.
4. pre=1000, post=100 with AW=10 -> post saturated to 23; L=1024. Readout wraps the RAM correctly and rd_last appears on the 1024th sample.
5. abort during POST -> state=0 next cycle, done stays 0. A new arm captures cleanly. Simultaneous arm+abort in IDLE -> stays IDLE.
6. rstn low for 1 cycle during readout -> all outputs at reset values. rd_req then gets no response until the next completed capture.
